// File: rtl/multi_clk_div_pkg.sv
// -----------------------------------------------------------------------------
// multi_clk_div_pkg
// Shared types and helpers for the multi-channel clock divider.
//   state_t     : RESTART / SETTLE / LOCKED sequencing of the whole block
//   chan_cfg_t  : per-channel divide ratio, high time and phase offset
//   cfg_is_bad  : legality check applied to every accepted request
// Config fields are carried at CFG_W bits; the top zero-extends its
// CNT_WIDTH-wide inputs into them, so CNT_WIDTH must not exceed CFG_W.
// -----------------------------------------------------------------------------
package multi_clk_div_pkg;

   localparam int CFG_W = 16;

   typedef enum logic [1:0] {
      ST_RESTART = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   typedef struct packed {
      logic [CFG_W-1:0] div;
      logic [CFG_W-1:0] high;
      logic [CFG_W-1:0] phase;
   } chan_cfg_t;

   // A request is unusable if it targets a missing channel, asks for a
   // ratio below 2, or has a high time / phase that does not fit the period.
   function automatic logic cfg_is_bad(input logic [2:0] chan,
                                       input chan_cfg_t  cfg,
                                       input int         num_clocks);
      return (int'(chan) >= num_clocks)
          || (cfg.div < CFG_W'(2))
          || (cfg.high == '0)
          || (cfg.high >= cfg.div)
          || (cfg.phase >= cfg.div);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: a counter running modulo cfg.div, a registered
// divided clock and a one-cycle enable aligned with its rising edge.
//   clk, rst_n : reference clock, async active-low reset
//   restart    : preload the counter so the rising edge lags by cfg.phase
//   mute       : force outclk/clk_en low this edge (a commit is in flight)
//   cfg        : div / high / phase for this channel
//   outclk     : registered (cnt < high)
//   clk_en     : registered (cnt == 0)
// -----------------------------------------------------------------------------
module clk_div_chan
   import multi_clk_div_pkg::*;
#(
   parameter int CNT_WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      restart,
   input  logic      mute,
   input  chan_cfg_t cfg,
   output logic      outclk,
   output logic      clk_en
);

   logic [CNT_WIDTH-1:0] cnt;
   logic [CFG_W-1:0]     cnt_ext;

   assign cnt_ext = CFG_W'(cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         outclk <= 1'b0;
         clk_en <= 1'b0;
      end else if (restart) begin
         // (div - phase) mod div: counting up from here reaches 0 after
         // exactly phase cycles, delaying the rising edge by phase.
         cnt    <= (cfg.phase == '0) ? '0 : CNT_WIDTH'(cfg.div - cfg.phase);
         outclk <= 1'b0;
         clk_en <= 1'b0;
      end else begin
         if (mute) begin
            outclk <= 1'b0;
            clk_en <= 1'b0;
         end else begin
            outclk <= (cnt_ext < cfg.high);
            clk_en <= (cnt == '0);
         end
         cnt <= (cnt_ext == cfg.div - CFG_W'(1)) ? '0 : cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/multi_clk_div.sv
// -----------------------------------------------------------------------------
// multi_clk_div
// NUM_CLOCKS programmable clock dividers sharing one refclk. A committed
// reconfiguration restarts every channel together, then the block waits
// LOCK_DELAY cycles before reporting locked.
//   refclk, rst_n         : clock, async active-low reset
//   cfg_valid / cfg_ready : request handshake (ready is low only in RESTART)
//   cfg_chan              : target channel
//   cfg_div/high/phase    : new divide ratio, high cycles, phase offset
//   cfg_err               : one-cycle pulse after a rejected request
//   outclk                : divided clocks
//   clk_en                : one pulse per period, with the outclk rising edge
//   locked                : all channels running the committed configuration
// -----------------------------------------------------------------------------
module multi_clk_div
   import multi_clk_div_pkg::*;
#(
   parameter int NUM_CLOCKS   = 4,
   parameter int CNT_WIDTH    = 8,
   parameter int DEFAULT_DIV  = 2,
   parameter int DEFAULT_HIGH = 1,
   parameter int LOCK_DELAY   = 16
) (
   input  logic                  refclk,
   input  logic                  rst_n,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [2:0]            cfg_chan,
   input  logic [CNT_WIDTH-1:0]  cfg_div,
   input  logic [CNT_WIDTH-1:0]  cfg_high,
   input  logic [CNT_WIDTH-1:0]  cfg_phase,
   output logic                  cfg_err,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] clk_en,
   output logic                  locked
);

   localparam int SETTLE_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_DELAY - 1);
   localparam chan_cfg_t RESET_CFG = '{
      div:   CFG_W'(DEFAULT_DIV),
      high:  CFG_W'(DEFAULT_HIGH),
      phase: '0
   };

   state_t              state, state_n;
   logic [SETTLE_W-1:0] settle_cnt, settle_cnt_n;
   chan_cfg_t           cfg_q [NUM_CLOCKS];
   chan_cfg_t           req;
   logic                accept, req_bad, commit, restart;

   assign req = '{
      div:   CFG_W'(cfg_div),
      high:  CFG_W'(cfg_high),
      phase: CFG_W'(cfg_phase)
   };

   assign cfg_ready = (state != ST_RESTART);
   assign locked    = (state == ST_LOCKED);
   assign restart   = (state == ST_RESTART);
   assign accept    = cfg_valid && cfg_ready;
   assign req_bad   = cfg_is_bad(cfg_chan, req, NUM_CLOCKS);
   assign commit    = accept && !req_bad;

   // --- sequencing -----------------------------------------------------------
   always_ff @(posedge refclk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         state      <= ST_RESTART;
         settle_cnt <= '0;
      end else begin
         state      <= state_n;
         settle_cnt <= settle_cnt_n;
      end
   end

   always_comb begin
      // NOTE: defaults first, so every path assigns every output and no
      // latch is inferred.
      state_n      = state;
      settle_cnt_n = settle_cnt;
      unique case (state)
         ST_RESTART: begin
            state_n      = ST_SETTLE;
            settle_cnt_n = '0;
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_n = ST_LOCKED;
            end else begin
               settle_cnt_n = settle_cnt + SETTLE_W'(1);
            end
         end
         ST_LOCKED: begin
            state_n = ST_LOCKED;
         end
         default: begin
            state_n = ST_RESTART;
         end
      endcase
      // A commit wins over everything: restart all channels and begin the
      // lock count again, even if already part-way through SETTLE.
      if (commit) begin
         state_n      = ST_RESTART;
         settle_cnt_n = '0;
      end
   end

   // --- configuration registers ---------------------------------------------
   always_ff @(posedge refclk or negedge rst_n) begin
      // NOTE: this register array is small control state that must come up at
      // the defaults, so it is reset; a true data RAM would not be.
      if (!rst_n) begin
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            cfg_q[i] <= RESET_CFG;
         end
      end else if (commit) begin
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_chan == 3'(i)) begin
               cfg_q[i] <= req;
            end
         end
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept && req_bad;
      end
   end

   // --- channels --------------------------------------------------------------
   for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
      clk_div_chan #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_chan (
         .clk     (refclk),
         .rst_n   (rst_n),
         .restart (restart),
         .mute    (commit),
         .cfg     (cfg_q[i]),
         .outclk  (outclk[i]),
         .clk_en  (clk_en[i])
      );
   end

endmodule

// File: tb/tb_multi_clk_div.sv
// -----------------------------------------------------------------------------
// tb_multi_clk_div
// Scoreboard bench: every stimulus pushes the expected per-cycle outputs
// (from a period/high/phase formula) into a queue; each test pops and
// compares one entry per refclk cycle, sampled on the falling edge.
// Sample index j counts cycles since the RESTART cycle (j = 0).
// -----------------------------------------------------------------------------
module tb_multi_clk_div;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int LD  = 16;

   logic           refclk = 1'b0;
   logic           rst_n;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [2:0]     cfg_chan;
   logic [CW-1:0]  cfg_div, cfg_high, cfg_phase;
   logic           cfg_err;
   logic [NCH-1:0] outclk, clk_en;
   logic           locked;

   typedef struct packed {
      logic [NCH-1:0] outclk;
      logic [NCH-1:0] clk_en;
      logic           locked;
      logic           ready;
      logic           err;
   } obs_t;

   obs_t sb[$];
   obs_t got, want;
   int   n_pass  = 0;
   int   n_total = 0;

   int   m_div   [NCH];
   int   m_high  [NCH];
   int   m_phase [NCH];
   int   jn;
   bit   pend_err;

   always #5 refclk = ~refclk;

   multi_clk_div #(
      .NUM_CLOCKS   (NCH),
      .CNT_WIDTH    (CW),
      .DEFAULT_DIV  (2),
      .DEFAULT_HIGH (1),
      .LOCK_DELAY   (LD)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .outclk    (outclk),
      .clk_en    (clk_en),
      .locked    (locked)
   );

   function automatic obs_t observe();
      obs_t o;
      o.outclk = outclk;
      o.clk_en = clk_en;
      o.locked = locked;
      o.ready  = cfg_ready;
      o.err    = cfg_err;
      return o;
   endfunction

   // Outputs j cycles after RESTART: silent for j = 0 and 1, then channel
   // position ((div - phase) mod div + j - 2) mod div.
   function automatic obs_t exp_at(int j, bit err);
      obs_t e;
      int   c0, c;
      e        = '0;
      e.err    = err;
      e.ready  = (j >= 1);
      e.locked = (j >= LD + 1);
      if (j >= 2) begin
         for (int ch = 0; ch < NCH; ch++) begin
            c0 = (m_phase[ch] == 0) ? 0 : m_div[ch] - m_phase[ch];
            c  = (c0 + j - 2) % m_div[ch];
            e.outclk[ch] = (c < m_high[ch]);
            e.clk_en[ch] = (c == 0);
         end
      end
      return e;
   endfunction

   function automatic void queue_samples(int n);
      for (int k = 0; k < n; k++) begin
         sb.push_back(exp_at(jn, pend_err));
         pend_err = 1'b0;
         jn++;
      end
   endfunction

   function automatic void model_defaults();
      for (int ch = 0; ch < NCH; ch++) begin
         m_div[ch]   = 2;
         m_high[ch]  = 1;
         m_phase[ch] = 0;
      end
   endfunction

   // Drive one request for the next rising edge and update the model.
   task automatic request(input int chan, input int div, input int high,
                          input int phase);
      bit bad;
      cfg_valid = 1'b1;
      cfg_chan  = 3'(chan);
      cfg_div   = CW'(div);
      cfg_high  = CW'(high);
      cfg_phase = CW'(phase);
      bad = (chan >= NCH) || (div < 2) || (high == 0) || (high >= div)
         || (phase >= div);
      if (bad) begin
         pend_err = 1'b1;
      end else begin
         m_div[chan]   = div;
         m_high[chan]  = high;
         m_phase[chan] = phase;
         jn            = 0;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_chan  = '0;
      cfg_div   = '0;
      cfg_high  = '0;
      cfg_phase = '0;
      repeat (3) @(negedge refclk);
      got = observe();
      n_total++;
      if (got !== obs_t'('0))
         $display("FAIL reset_hold: got %b expected %b", got, obs_t'('0));
      else
         n_pass++;
      rst_n = 1'b1;
      model_defaults();
      jn       = 1;
      pend_err = 1'b0;
      queue_samples(24);
      repeat (24) begin
         @(negedge refclk);
         got  = observe();
         want = sb.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL reset_release j=%0d: got %b expected %b", jn - sb.size() - 1, got, want);
         else
            n_pass++;
      end
   endtask

   task automatic test_program_phase();
      request(1, 5, 2, 3);
      queue_samples(30);
      repeat (30) begin
         @(negedge refclk);
         cfg_valid = 1'b0;
         got  = observe();
         want = sb.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL program_phase: got %b expected %b", got, want);
         else
            n_pass++;
      end
   endtask

   task automatic test_reject();
      int tbl [6][4] = '{
         '{2, 5, 5, 0},   // high == div
         '{6, 4, 2, 0},   // channel beyond NUM_CLOCKS
         '{4, 4, 2, 0},   // channel == NUM_CLOCKS
         '{0, 1, 1, 0},   // div below 2
         '{3, 4, 0, 0},   // zero high time
         '{3, 4, 2, 4}    // phase == div
      };
      for (int t = 0; t < 6; t++) begin
         request(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
         queue_samples(3);
         repeat (3) begin
            @(negedge refclk);
            cfg_valid = 1'b0;
            got  = observe();
            want = sb.pop_front();
            n_total++;
            if (got !== want)
               $display("FAIL reject[%0d]: got %b expected %b", t, got, want);
            else
               n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      request(2, 3, 1, 1);
      queue_samples(9);
      repeat (9) begin
         @(negedge refclk);
         cfg_valid = 1'b0;
         got  = observe();
         want = sb.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL settle_first: got %b expected %b", got, want);
         else
            n_pass++;
      end
      request(3, 4, 2, 2);
      queue_samples(20);
      repeat (20) begin
         @(negedge refclk);
         cfg_valid = 1'b0;
         got  = observe();
         want = sb.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL settle_restart: got %b expected %b", got, want);
         else
            n_pass++;
      end
   endtask

   task automatic test_reset_mid_settle();
      request(0, 3, 1, 0);
      queue_samples(6);
      repeat (6) begin
         @(negedge refclk);
         cfg_valid = 1'b0;
         got  = observe();
         want = sb.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL pre_reset: got %b expected %b", got, want);
         else
            n_pass++;
      end
      // Reset lands together with a legal request, which must be discarded.
      cfg_valid = 1'b1;
      cfg_chan  = 3'd1;
      cfg_div   = CW'(6);
      cfg_high  = CW'(3);
      cfg_phase = '0;
      rst_n     = 1'b0;
      #1;
      got = observe();
      n_total++;
      if (got !== obs_t'('0))
         $display("FAIL reset_async: got %b expected %b", got, obs_t'('0));
      else
         n_pass++;
      repeat (2) @(negedge refclk);
      got = observe();
      n_total++;
      if (got !== obs_t'('0))
         $display("FAIL reset_mid_hold: got %b expected %b", got, obs_t'('0));
      else
         n_pass++;
      cfg_valid = 1'b0;
      rst_n     = 1'b1;
      model_defaults();
      jn       = 1;
      pend_err = 1'b0;
      queue_samples(20);
      repeat (20) begin
         @(negedge refclk);
         got  = observe();
         want = sb.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL reset_defaults: got %b expected %b", got, want);
         else
            n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_program_phase();
      test_reject();
      test_back_to_back();
      test_reset_mid_settle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 Parameter NUM_CLOCKS, default 4: number of derived clock channels, legal range 1..8.
REQ-002 Parameter CNT_WIDTH, default 8: width of the divide, high-time and phase fields.
REQ-003 Parameter DEFAULT_DIV, default 2: divide ratio loaded into every channel at reset.
REQ-004 Parameter DEFAULT_HIGH, default 1: high-time loaded into every channel at reset.
REQ-005 Parameter LOCK_DELAY, default 16: number of refclk cycles in SETTLE before locked asserts.
REQ-006 Port refclk, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 Port cfg_valid, input, 1: reconfiguration request.
REQ-009 Port cfg_ready, output, 1: the block can accept a request.
REQ-010 Port cfg_chan, input, 3: target channel index.
REQ-011 Port cfg_div / cfg_high / cfg_phase, input, CNT_WIDTH each: divide ratio, high cycles, phase offset in refclk cycles.
REQ-012 Port cfg_err, output, 1: one-cycle pulse when a request is rejected.
REQ-013 Port outclk, output, NUM_CLOCKS: registered divided clocks.
REQ-014 Port clk_en, output, NUM_CLOCKS: one-cycle pulse per channel period, coincident with the outclk rising edge.
REQ-015 Port locked, output, 1: all channels running with the committed configuration.

Function
REQ-016 Each channel SHALL hold div, high and phase registers and a counter cnt that increments modulo div.
REQ-017 outclk[i] SHALL be registered as (cnt_i < high_i) during SETTLE and LOCKED, and SHALL be 0 in RESTART.
REQ-018 clk_en[i] SHALL be registered as (cnt_i == 0) during SETTLE and LOCKED, and SHALL be 0 in RESTART.
REQ-019 The FSM SHALL have states RESTART, SETTLE and LOCKED; RESTART lasts exactly one cycle and then moves to SETTLE.
REQ-020 In RESTART every cnt_i SHALL be loaded with (div_i - phase_i) mod div_i, so that the outclk[i] rising edge lags a phase-0 channel by phase_i cycles.
REQ-021 SETTLE SHALL count LOCK_DELAY cycles and then move to LOCKED; locked = 1 only in LOCKED.
REQ-022 cfg_ready SHALL be 1 in SETTLE and LOCKED and 0 in RESTART.
REQ-023 A request is accepted on the cycle cfg_valid and cfg_ready are both 1.
REQ-024 An accepted request SHALL be rejected if any of the following holds: cfg_chan >= NUM_CLOCKS, cfg_div < 2, cfg_high == 0, cfg_high >= cfg_div, or cfg_phase >= cfg_div.
REQ-025 A rejected request SHALL pulse cfg_err on the next cycle and SHALL change no state.
REQ-026 A valid request SHALL commit the channel registers, and the FSM SHALL enter RESTART on the next cycle.
REQ-027 locked SHALL drop in that same next cycle, and all channels SHALL restart together.
REQ-028 A valid request accepted during SETTLE SHALL restart the LOCK_DELAY count from zero.
REQ-029 Counter wrap: cnt == div-1 SHALL go to 0; no other value is reachable after RESTART.
REQ-030 With div = 2 and high = 1, outclk SHALL toggle every cycle (refclk/2).

Reset
REQ-031 While rst_n = 0, all state SHALL be cleared asynchronously.
REQ-032 Reset values: div = DEFAULT_DIV, high = DEFAULT_HIGH, phase = 0, cnt = 0; outputs outclk = 0, clk_en = 0, locked = 0, cfg_err = 0, cfg_ready = 0; FSM = RESTART.
REQ-033 Reset asserted mid-SETTLE or mid-request SHALL discard any pending commit.
REQ-034 The first cycle after rst_n deasserts SHALL be RESTART.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the per-channel config struct (div, high, phase) and the error-check function.
REQ-036 A sub-module clk_div_chan (one counter, outclk and clk_en generation, restart preload) SHALL be instantiated NUM_CLOCKS times; the FSM and configuration handshake SHALL live in the top level.

Verification
REQ-037 Reset release with defaults and LOCK_DELAY = 16: all outclk are refclk/2 and in phase; locked rises on the 18th cycle after release.
REQ-038 Program ch1 with div = 5, high = 2, phase = 3: after relock, ch1 period is 5 cycles with 2 high, and its rising edge falls 3 cycles after ch0's rising edge (ch0 at its defaults).
REQ-039 Request with cfg_high = 5, cfg_div = 5: cfg_err pulses once, locked stays 1, and outclk is unchanged.
REQ-040 Second valid request 8 cycles into SETTLE: locked stays 0 until LOCK_DELAY + 2 cycles after the second acceptance.
REQ-041 cfg_chan = 6 with NUM_CLOCKS = 4: rejected, cfg_err pulses.
REQ-042 rst_n pulsed low during SETTLE: outputs clear immediately; the default configuration is restored after release.
